// File: rtl/dom_pkg.sv
// Shared definitions for the 2-share DOM datapath.
// The share count and nominal share width are common to every masked block.
package dom_pkg;

    localparam int DOM_SHARES = 2;
    localparam int DOM_WIDTH  = 8;

    typedef logic [DOM_WIDTH-1:0] share_t;

    typedef struct packed {
        share_t s0;
        share_t s1;
    } share_pair_t;

endpackage

// File: rtl/dom_share_reg.sv
// Single-domain share register with load and clear.
// One instance per share keeps the domains separate in the netlist.
module dom_share_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] share_d;
    logic [WIDTH-1:0] share_q;

    always_comb begin
        share_d = share_q;
        if (ld_i) begin
            share_d = d_i;
        end else if (clr_i) begin
            share_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            share_q <= '0;
        end else begin
            share_q <= share_d;
        end
    end

    assign q_o = share_q;

endmodule

// File: rtl/dom_share_decoder.sv
// Masked-to-unmasked boundary: registers each share in its own domain,
// then recombines with XOR one stage later behind a valid/ready pipeline.
module dom_share_decoder
    import dom_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int COUNT_W       = 8,
    parameter bit CLEAR_ON_IDLE = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   Q0_i,
    input  logic [WIDTH-1:0]   Q1_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic [COUNT_W-1:0] count_o
);

    logic               s1_v_d, s1_v_q;
    logic               s2_v_d, s2_v_q;
    logic [WIDTH-1:0]   data_d, data_q;
    logic [COUNT_W-1:0] count_d, count_q;
    logic [WIDTH-1:0]   r0, r1;
    logic               accept, adv, fire, s1_clr;

    // ready_o depends on ready_i and state only, never on valid_i
    assign ready_o = !s1_v_q || !s2_v_q || ready_i;
    assign accept  = valid_i && ready_o;
    assign adv     = s1_v_q && (!s2_v_q || ready_i);
    assign fire    = s2_v_q && ready_i;
    assign s1_clr  = CLEAR_ON_IDLE && adv && !accept;

    dom_share_reg #(.WIDTH(WIDTH)) u_reg0 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ld_i  (accept),
        .clr_i (s1_clr),
        .d_i   (Q0_i),
        .q_o   (r0)
    );

    dom_share_reg #(.WIDTH(WIDTH)) u_reg1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ld_i  (accept),
        .clr_i (s1_clr),
        .d_i   (Q1_i),
        .q_o   (r1)
    );

    always_comb begin
        s1_v_d  = s1_v_q;
        s2_v_d  = s2_v_q;
        data_d  = data_q;
        count_d = count_q;
        if (accept) begin
            s1_v_d = 1'b1;
        end else if (adv) begin
            s1_v_d = 1'b0;
        end
        if (adv) begin
            s2_v_d = 1'b1;
            data_d = r0 ^ r1;
        end else if (fire) begin
            s2_v_d = 1'b0;
            if (CLEAR_ON_IDLE) begin
                data_d = '0;
            end
        end
        if (fire) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s2_v_q  <= s2_v_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_o = s2_v_q;
    assign data_o  = data_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_dom_share_decoder.sv
// Scoreboard bench for dom_share_decoder; a second instance with a 4-bit
// counter shares the same stimulus to exercise counter wrap.
module tb_dom_share_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b1;
    logic [7:0] Q0_i = '0;
    logic [7:0] Q1_i = '0;
    logic       ready_o, valid_o;
    logic [7:0] data_o, count_o;
    logic       ready_o_w, valid_o_w;
    logic [7:0] data_o_w;
    logic [3:0] count_o_w;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_fire   = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_a;

    always #5 clk_i = ~clk_i;

    dom_share_decoder #(.WIDTH(8), .COUNT_W(8), .CLEAR_ON_IDLE(1'b1)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .Q0_i(Q0_i), .Q1_i(Q1_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .count_o(count_o)
    );

    dom_share_decoder #(.WIDTH(8), .COUNT_W(4), .CLEAR_ON_IDLE(1'b1)) u_dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o_w),
        .Q0_i(Q0_i), .Q1_i(Q1_i), .valid_o(valid_o_w), .ready_i(ready_i),
        .data_o(data_o_w), .count_o(count_o_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // output monitor: a word fires at the coming posedge
    always @(negedge clk_i) begin
        if (!rst_i && valid_o === 1'b1 && ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexp", valid_o, 1'b0);
            end else begin
                chk("sb_data", data_o, sb.pop_front());
                chk("sb_data_w", data_o_w, data_o);
            end
            n_fire++;
        end
    end

    // drive a pair starting #1 after a posedge; returns at the accepting posedge
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        logic acc;
        bit   done;
        valid_i = 1'b1;
        Q0_i    = a;
        Q1_i    = b;
        done    = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            if (acc) begin
                sb.push_back(a ^ b);
                done = 1;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk_i);
            #1;
            if (sb.size() == 0 && valid_o == 1'b0) done = 1;
        end
        chk("drain_sb", sb.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_r0"},   u_dut.u_reg0.q_o, 8'h00);
        chk({tag, "_r1"},   u_dut.u_reg1.q_o, 8'h00);
        chk({tag, "_r0w"},  u_dut_w.u_reg0.q_o, 8'h00);
        chk({tag, "_r1w"},  u_dut_w.u_reg1.q_o, 8'h00);
        chk({tag, "_data"}, data_o, 8'h00);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data",  data_o, 8'h00);
        chk("rst_count", count_o, 8'h00);
        chk("rst_ready", ready_o, 1'b1);
        rst_i = 1'b0;

        // single word
        send(8'h3C, 8'h99);
        #1;
        valid_i = 1'b0;
        chk("lat1_valid", valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        chk("lat2_valid", valid_o, 1'b1);
        chk("lat2_data",  data_o, 8'hA5);
        chk("lat2_count", count_o, 8'h00);
        @(posedge clk_i);
        #1;
        chk("single_count", count_o, 8'h01);
        chk("single_valid", valid_o, 1'b0);
        check_idle("single_idle");

        // streaming, 16 back-to-back pairs
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            #1;
        end
        valid_i = 1'b0;
        drain();
        chk("stream_count", count_o, 8'(n_fire));
        chk("stream_count_val", count_o, 8'd17);
        chk("wrap_count_w", count_o_w, 4'h1);
        check_idle("wrap_idle");

        // backpressure
        exp_a = 8'h12 ^ 8'hF0;
        send(8'h12, 8'hF0);
        #1;
        ready_i = 1'b0;
        send(8'h55, 8'h0F);
        #1;
        valid_i = 1'b1;
        Q0_i    = 8'hC3;
        Q1_i    = 8'h81;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_ready", ready_o, 1'b0);
            chk("bp_valid", valid_o, 1'b1);
            chk("bp_hold",  data_o, exp_a);
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        send(8'hC3, 8'h81);
        #1;
        valid_i = 1'b0;
        drain();
        chk("bp_count", count_o, 8'(n_fire));
        chk("bp_count_w", count_o_w, 4'(n_fire));
        check_idle("bp_idle");

        // mid-flight reset with both stages full
        send(8'hAA, 8'h01);
        #1;
        ready_i = 1'b0;
        send(8'hBB, 8'h02);
        #1;
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk_i);
        #1;
        sb.delete();
        n_fire = 0;
        chk("mrst_valid", valid_o, 1'b0);
        chk("mrst_count", count_o, 8'h00);
        chk("mrst_data",  data_o, 8'h00);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            chk("mrst_quiet", valid_o, 1'b0);
        end
        chk("mrst_count_end", count_o, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
